// File: rtl/parity_serial_tx.sv
// parity_serial_tx
//   Serialises one data byte plus its parity bit per valid/ready handshake.
//   Frame, LSB first: start(0), DATA_W data bits, parity, stop(1).
//   Each bit is held for CLKS_PER_BIT clocks. The line idles high.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   data_in     byte to send, captured on accept
//   parity_in   parity of data_in, captured on accept
//   in_valid    upstream offers data_in/parity_in
//   in_ready    block can accept (IDLE and not in reset)
//   tx_out      registered serial line, idle high
//   busy        registered, high while a frame is in progress
//   frame_done  one-clock pulse in the last clock of the stop bit
module parity_serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              parity_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic          ODD      = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_q, par_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_c;
    logic                accept;
    logic                wrap;

    assign in_ready   = (state_q == IDLE) && !rst;
    assign accept     = in_valid && in_ready;
    assign wrap       = (cnt_q == CNT_LAST);
    assign tx_out     = tx_q;
    assign busy       = busy_q;
    // An aborted frame never reports completion.
    assign frame_done = done_c && !rst;

    // tx_d is the line value for the *next* clock, so tx_out changes on the
    // same edge that moves the FSM into the state the bit belongs to.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_c  = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d = START;
                    cnt_d   = '0;
                    bit_d   = '0;
                    shift_d = data_in;
                    par_d   = parity_in;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (wrap) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (wrap) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = PARITY;
                        tx_d    = par_q ^ ODD;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                    end
                end
            end
            PARITY: begin
                if (wrap) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (wrap) begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench for parity_serial_tx (DATA_W=8, CLKS_PER_BIT=4).
// Two instances share inputs: even parity (main) and PARITY_ODD=1.
// Frames are captured as 44-bit vectors indexed by (clock after accept - 1).
module tb_parity_serial_tx;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       parity_in;
    logic       in_valid;
    logic       in_ready, tx_out, busy, frame_done;
    logic       in_ready_o, tx_out_o, busy_o, frame_done_o;

    int total = 0;
    int bad   = 0;

    parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .parity_in(parity_in),
        .in_valid(in_valid), .in_ready(in_ready), .tx_out(tx_out),
        .busy(busy), .frame_done(frame_done)
    );

    parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst(rst), .data_in(data_in), .parity_in(parity_in),
        .in_valid(in_valid), .in_ready(in_ready_o), .tx_out(tx_out_o),
        .busy(busy_o), .frame_done(frame_done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [43:0] DONE_EXP = 44'h800_0000_0000;
    localparam logic [43:0] BUSY_EXP = 44'hFFF_FFFF_FFFF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // in_valid must already be high; returns at the sample point of clock 1.
    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                tick();
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    // Captures clocks 1..44 after accept; ends at the sample point of clock 45.
    // At clock chg_k the input byte is swapped for chg_d (0 = no swap).
    task automatic capture(input int chg_k, input logic [7:0] chg_d,
                           output logic [43:0] ln, output logic [43:0] lo,
                           output logic [43:0] dn, output logic [43:0] bs);
        for (int k = 1; k <= 44; k++) begin
            ln[k-1] = tx_out;
            lo[k-1] = tx_out_o;
            dn[k-1] = frame_done;
            bs[k-1] = busy;
            if (k == chg_k) begin
                data_in   = chg_d;
                parity_in = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; data_in = 8'h55; parity_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if ({tx_out, busy, in_ready, frame_done} !== 4'b1000) begin
                bad++;
                $display("FAIL reset_hold clk%0d: tx/busy/rdy/done=%b want 1000", c,
                         {tx_out, busy, in_ready, frame_done});
            end
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: in_ready=%b busy=%b want 1 0", in_ready, busy);
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || tx_out !== 1'b1) begin
            bad++;
            $display("FAIL reset_no_accept: busy=%b tx=%b want 0 1", busy, tx_out);
        end
    endtask

    task automatic test_zero();
        logic [43:0] ln, lo, dn, bs;
        bit ok;
        data_in = 8'h00; parity_in = 1'b0; in_valid = 1'b1;
        wait_accept(ok);
        in_valid = 1'b0;
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL zero_accept: timeout"); end
        capture(0, 8'h00, ln, lo, dn, bs);
        total++;
        if (ln !== 44'hF00_0000_0000) begin
            bad++; $display("FAIL zero_line: got %h want %h", ln, 44'hF00_0000_0000);
        end
        total++;
        if (dn !== DONE_EXP) begin
            bad++; $display("FAIL zero_done: got %h want %h", dn, DONE_EXP);
        end
        total++;
        if (bs !== BUSY_EXP) begin
            bad++; $display("FAIL zero_busy: got %h want %h", bs, BUSY_EXP);
        end
        total++;
        if ({in_ready, busy, tx_out} !== 3'b101) begin
            bad++; $display("FAIL zero_clk45: rdy/busy/tx=%b want 101", {in_ready, busy, tx_out});
        end
    endtask

    task automatic test_one();
        logic [43:0] ln, lo, dn, bs;
        logic [7:0]  dec;
        bit ok;
        data_in = 8'h01; parity_in = 1'b1; in_valid = 1'b1;
        wait_accept(ok);
        in_valid = 1'b0;
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL one_accept: timeout"); end
        capture(0, 8'h00, ln, lo, dn, bs);
        total++;
        if (ln !== 44'hFF0_0000_00F0) begin
            bad++; $display("FAIL one_line: got %h want %h", ln, 44'hFF0_0000_00F0);
        end
        // decode from mid-bit samples
        for (int b = 0; b < 8; b++) dec[b] = ln[4 + 4*b + 2];
        total++;
        if (dec !== 8'h01) begin
            bad++; $display("FAIL one_decode: got %h want 01", dec);
        end
        total++;
        if (dn !== DONE_EXP) begin
            bad++; $display("FAIL one_done: got %h want %h", dn, DONE_EXP);
        end
    endtask

    task automatic test_aa_parity_mode();
        logic [43:0] ln, lo, dn, bs;
        bit ok;
        data_in = 8'hAA; parity_in = 1'b0; in_valid = 1'b1;
        wait_accept(ok);
        in_valid = 1'b0;
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL aa_accept: timeout"); end
        capture(0, 8'h00, ln, lo, dn, bs);
        total++;
        if (ln !== 44'hF0F_0F0F_0F00) begin
            bad++; $display("FAIL aa_even_line: got %h want %h", ln, 44'hF0F_0F0F_0F00);
        end
        total++;
        if (lo !== 44'hFFF_0F0F_0F00) begin
            bad++; $display("FAIL aa_odd_line: got %h want %h", lo, 44'hFFF_0F0F_0F00);
        end
    endtask

    task automatic test_back_to_back();
        logic [43:0] ln, lo, dn, bs;
        bit ok;
        data_in = 8'h3C; parity_in = 1'b0; in_valid = 1'b1;
        wait_accept(ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL b2b_accept: timeout"); end
        capture(10, 8'hFF, ln, lo, dn, bs);
        total++;
        if (ln !== 44'hF00_0FFF_F000) begin
            bad++; $display("FAIL b2b_frame1: got %h want %h", ln, 44'hF00_0FFF_F000);
        end
        total++;
        if (dn !== DONE_EXP) begin
            bad++; $display("FAIL b2b_done1: got %h want %h", dn, DONE_EXP);
        end
        // clock 45: the mandatory idle clock, in_valid still high
        total++;
        if ({in_ready, busy, tx_out} !== 3'b101) begin
            bad++; $display("FAIL b2b_gap: rdy/busy/tx=%b want 101", {in_ready, busy, tx_out});
        end
        tick();
        in_valid = 1'b0;
        capture(0, 8'h00, ln, lo, dn, bs);
        total++;
        if (ln !== 44'hF0F_FFFF_FFF0) begin
            bad++; $display("FAIL b2b_frame2: got %h want %h", ln, 44'hF0F_FFFF_FFF0);
        end
        total++;
        if (bs !== BUSY_EXP) begin
            bad++; $display("FAIL b2b_busy2: got %h want %h", bs, BUSY_EXP);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [43:0] ln, lo, dn, bs;
        bit ok;
        bit quiet;
        data_in = 8'hC3; parity_in = 1'b0; in_valid = 1'b1;
        wait_accept(ok);
        in_valid = 1'b0;
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL rstmid_accept: timeout"); end
        // now at clock 1; advance to clock 18 (inside data bit 3)
        for (int k = 1; k < 18; k++) tick();
        total++;
        if (busy !== 1'b1 || tx_out !== 1'b0) begin
            bad++; $display("FAIL rstmid_pre: busy=%b tx=%b want 1 0", busy, tx_out);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({tx_out, busy, frame_done} !== 3'b100) begin
            bad++; $display("FAIL rstmid_abort: tx/busy/done=%b want 100", {tx_out, busy, frame_done});
        end
        rst = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (frame_done !== 1'b0 || tx_out !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
            tick();
        end
        total++;
        if (quiet !== 1'b1) begin
            bad++; $display("FAIL rstmid_quiet: line activity after abort (quiet=%b want 1)", quiet);
        end
        data_in = 8'h5A; parity_in = 1'b0; in_valid = 1'b1;
        wait_accept(ok);
        in_valid = 1'b0;
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL rstmid_accept2: timeout"); end
        capture(0, 8'h00, ln, lo, dn, bs);
        total++;
        if (ln !== 44'hF00_F0FF_0F00) begin
            bad++; $display("FAIL rstmid_5a_line: got %h want %h", ln, 44'hF00_F0FF_0F00);
        end
        total++;
        if (dn !== DONE_EXP) begin
            bad++; $display("FAIL rstmid_5a_done: got %h want %h", dn, DONE_EXP);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; data_in = 8'h00; parity_in = 1'b0;
        test_reset();
        test_zero();
        test_one();
        test_aa_parity_mode();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
